// File: rtl/relu_pool_pkg.sv
// Shared sizes and sample types for the ReLU / requantise / 2x2 max-pool stage
// that sits behind the 3x3 conv accumulator stream.
package relu_pool_pkg;

    localparam int IN_W   = 32;  // conv accumulator width
    localparam int OUT_W  = 16;  // pooled pixel width
    localparam int SHIFT  = 8;   // requant right shift after ReLU
    localparam int IMG_W  = 28;  // incoming row stride, including wrap columns
    localparam int CONV_W = 26;  // valid columns per row
    localparam int CONV_H = 26;  // rows per frame

    localparam int COL_W    = $clog2(IMG_W);
    localparam int ROW_W    = $clog2(CONV_H);
    localparam int LB_DEPTH = CONV_W / 2;
    localparam int LB_AW    = $clog2(LB_DEPTH);

    typedef logic signed [IN_W-1:0]  acc_t;
    typedef logic signed [OUT_W-1:0] pix_t;

    localparam pix_t OUT_MAX = pix_t'((2 ** (OUT_W - 1)) - 1);

endpackage

// File: rtl/relu_requant.sv
// Combinational ReLU, arithmetic right shift by SHIFT and saturation to OUT_W.
// sat flags samples whose shifted value exceeded OUT_MAX.
module relu_requant
    import relu_pool_pkg::*;
(
    input  logic signed [IN_W-1:0]  data_in,
    output logic signed [OUT_W-1:0] q,
    output logic                    sat
);

    localparam acc_t OUT_MAX_ACC = acc_t'(OUT_MAX);

    function automatic pix_t saturate(input acc_t y);
        return (y > OUT_MAX_ACC) ? OUT_MAX : pix_t'(y[OUT_W-1:0]);
    endfunction

    acc_t relu_x;
    acc_t shifted;

    // Clamp negatives to zero, scale down, then saturate into the pixel range.
    always_comb begin
        relu_x  = data_in[IN_W-1] ? '0 : data_in;
        shifted = relu_x >>> SHIFT;
        q       = saturate(shifted);
        sat     = (shifted > OUT_MAX_ACC);
    end

endmodule

// File: rtl/relu_maxpool2.sv
// ReLU + requant + 2x2 stride-2 max pooling over the conv accumulator stream.
// Wrap columns (col >= CONV_W) only advance the position counters.
// Optional build macro SAT_COUNT_EN adds a sticky 16-bit saturation counter
// (sat_cnt) that clears on an sof sample and on reset.
module relu_maxpool2
    import relu_pool_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  data_in,
    input  logic                    in_valid,
    input  logic                    sof,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    out_valid,
    output logic                    frame_last
`ifdef SAT_COUNT_EN
    ,
    output logic [15:0]             sat_cnt
`endif
);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_VALID = COL_W'(CONV_W);
    localparam logic [COL_W-1:0] COL_VLAST = COL_W'(CONV_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(CONV_H - 1);

    function automatic pix_t pix_max(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    logic [COL_W-1:0] col, cur_col;
    logic [ROW_W-1:0] row, cur_row;
    logic             col_ok;
    logic [LB_AW-1:0] lb_idx;
    pix_t             q, hold, pm, lb_rd;
    logic             sat;
    pix_t             lbuf [LB_DEPTH];

    relu_requant u_requant (
        .data_in (data_in),
        .q       (q),
        .sat     (sat)
    );

    // Position of the current sample (sof snaps it to the frame origin) and
    // the horizontal pair maximum / line-buffer read for its column pair.
    always_comb begin
        cur_col = sof ? '0 : col;
        cur_row = sof ? '0 : row;
        col_ok  = (cur_col < COL_VALID);
        lb_idx  = cur_col[LB_AW:1];
        pm      = pix_max(hold, q);
        lb_rd   = lbuf[lb_idx];
    end

    // Raster position counters, advanced once per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col <= cur_col + COL_W'(1);
                row <= cur_row;
            end
        end
    end

    // Even column parks its pixel; odd column on an odd row closes a window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= '0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            frame_last <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_last <= 1'b0;
            if (in_valid && col_ok) begin
                if (!cur_col[0]) begin
                    hold <= q;
                end else if (cur_row[0]) begin
                    data_out   <= pix_max(pm, lb_rd);
                    out_valid  <= 1'b1;
                    frame_last <= (cur_row == ROW_LAST) && (cur_col == COL_VLAST);
                end
            end
        end
    end

    // Line buffer keeps even-row pair maxima; always written before read.
    always_ff @(posedge clk) begin
        if (in_valid && col_ok && cur_col[0] && !cur_row[0]) begin
            lbuf[lb_idx] <= pm;
        end
    end

`ifdef SAT_COUNT_EN
    // Sticky count of saturated valid-column samples since the last sof.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (in_valid && col_ok) begin
            if (sof) begin
                sat_cnt <= sat ? 16'd1 : 16'd0;
            end else if (sat && (sat_cnt != 16'hFFFF)) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_relu_maxpool2.sv
// Self-checking bench for relu_maxpool2: directed and random frames are scored
// against a per-window reference computed directly from the pooled image.
module tb_relu_maxpool2;

    localparam int IW = 28;
    localparam int CW = 26;
    localparam int CH = 26;
    localparam int PW = 13;

    logic               clk;
    logic               rst_n;
    logic signed [31:0] data_in;
    logic               in_valid;
    logic               sof;
    logic signed [15:0] data_out;
    logic               out_valid;
    logic               frame_last;
`ifdef SAT_COUNT_EN
    logic [15:0]        sat_cnt;
`endif

    relu_maxpool2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .sof        (sof),
        .data_out   (data_out),
        .out_valid  (out_valid),
`ifdef SAT_COUNT_EN
        .sat_cnt    (sat_cnt),
`endif
        .frame_last (frame_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit last;
        int tag;
    } exp_t;

    exp_t exp_q[$];
    int   img [CH][IW];
    int   exp_map [PW][PW];
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    int   nneg   = 0;
    int   out_cnt = 0;
    int   last_out = 0;
    int   sat_model = 0;
    exp_t mon_e;

    task automatic check(input string tag, input longint obs, input longint expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference requantisation: ReLU, divide by 2^8, clip to 32767.
    function automatic int rq(input int v);
        int y;
        if (v <= 0) return 0;
        y = v / 256;
        return (y > 32767) ? 32767 : y;
    endfunction

    function automatic bit rq_sat(input int v);
        return (v > 0) && ((v / 256) > 32767);
    endfunction

    task automatic build_map();
        for (int pr = 0; pr < PW; pr++) begin
            for (int pc = 0; pc < PW; pc++) begin
                int m;
                m = 0;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (rq(img[2*pr+dr][2*pc+dc]) > m) m = rq(img[2*pr+dr][2*pc+dc]);
                exp_map[pr][pc] = m;
            end
        end
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < CH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = v;
    endtask

    task automatic fill_random();
        for (int r = 0; r < CH; r++) begin
            for (int c = 0; c < IW; c++) begin
                case ($urandom_range(0, 3))
                    0:       img[r][c] = -int'($urandom_range(1, 1 << 30));
                    1:       img[r][c] = int'($urandom_range(0, 1 << 20));
                    2:       img[r][c] = int'($urandom & 32'h7FFF_FFFF);
                    default: img[r][c] = 32767 * 256 + int'($urandom_range(0, 600)) - 300;
                endcase
            end
        end
    endtask

    // Drive n samples of img in raster order, with occasional idle cycles.
    task automatic stream(input int n, input bit use_sof);
        for (int idx = 0; idx < n; idx++) begin
            int r, c;
            r = idx / IW;
            c = idx % IW;
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            data_in  = img[r][c];
            in_valid = 1'b1;
            sof      = use_sof && (idx == 0);
            if (use_sof && idx == 0) sat_model = 0;
            if (c < CW && rq_sat(img[r][c]) && sat_model < 65535) sat_model++;
            if (c < CW && (c % 2) == 1 && (r % 2) == 1)
                exp_q.push_back('{val: exp_map[r/2][c/2], last: (r == CH-1 && c == CW-1), tag: nneg});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            sof      = 1'b0;
        end
    endtask

    task automatic settle_and_count(input string tag, input int base, input int n_exp);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_count"}, out_cnt - base, n_exp);
`ifdef SAT_COUNT_EN
        check({tag, "_sat_cnt"}, sat_cnt, sat_model);
`endif
    endtask

    task automatic run_frame(input string tag, input bit use_sof);
        int base;
        build_map();
        base = out_cnt;
        stream(IW * CH, use_sof);
        settle_and_count(tag, base, PW * PW);
    endtask

    // Output scoreboard: order, value, frame_last, one-clock latency, hold.
    always @(negedge clk) begin
        nneg++;
        if (!rst_n) begin
            last_out = 0;
        end else if (out_valid) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("data_out", longint'(data_out), mon_e.val);
                check("frame_last", frame_last, mon_e.last);
                check("latency", nneg, mon_e.tag + 2);
            end
            last_out = int'(data_out);
        end else begin
            check("frame_last_idle", frame_last, 0);
            check("data_out_hold", longint'(data_out), last_out);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout total=%0d passed=%0d", total, passed);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        data_in  = '0;
        in_valid = 1'b0;
        sof      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", longint'(data_out), 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_frame_last", frame_last, 0);
`ifdef SAT_COUNT_EN
        check("rst_sat_cnt", sat_cnt, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fill_const(4096);
        run_frame("const_4096", 1'b1);

        fill_const(-5000);
        run_frame("const_neg", 1'b1);

        fill_const(32'h7FFF_FFFF);
        run_frame("const_max", 1'b1);
`ifdef SAT_COUNT_EN
        check("sat_676", sat_cnt, 676);
`endif

        fill_const(0);
        img[0][0] = 256;
        img[0][1] = 1024;
        img[1][0] = 768;
        img[1][1] = 512;
        build_map();
        check("first_window_model", exp_map[0][0], 4);
        run_frame("first_window", 1'b1);

        fill_const(0);
        for (int r = 0; r < CH; r++) begin
            img[r][26] = 32'h7FFF_0000;
            img[r][27] = 32'h7FFF_0000;
        end
        run_frame("wrap_cols", 1'b1);

        fill_random();
        run_frame("random_a", 1'b1);
        fill_random();
        run_frame("random_b", 1'b1);

        // Reset in the middle of a frame, then a fresh frame without sof.
        begin
            int base;
            fill_const(512);
            build_map();
            base = out_cnt;
            stream(10 * IW + 5, 1'b1);
            settle_and_count("partial_rst", base, 5 * PW);
            rst_n = 1'b0;
            #1;
            check("midrst_data_out", longint'(data_out), 0);
            check("midrst_out_valid", out_valid, 0);
            check("midrst_frame_last", frame_last, 0);
            sat_model = 0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            run_frame("after_reset", 1'b0);
        end

        // Abandon a frame mid-way by starting a new one with sof.
        begin
            int base;
            fill_random();
            build_map();
            base = out_cnt;
            stream(10 * IW + 5, 1'b1);
            settle_and_count("partial_sof", base, 5 * PW);
            fill_const(512);
            run_frame("after_sof", 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
